alu_port: RTL
=============

# alu_port

Handshaked request/response front-end for the combinational `alu32_2x2`. It accepts one operation at a time from the issue stage and registers the operands so the ALU inputs are held stable for a programmable settle window. It then captures `ql`/`qh`/`fout` into a result register and presents them to writeback through a valid/ready response channel. Illegal opcodes are rejected with an exception response and never reach the ALU capture path.

## Interface
- `SETTLE`, default 8: cycles operands are held before capture for ops 0–3 and 5–17; legal range 1..31.
- `MUL_SETTLE`, default 16: same, for op 4 (32x32 multiply); legal range 1..31.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `req_valid` input, 1 bit: request present.
- `req_ready` output, 1 bit: block can accept a request this cycle.
- `req_op` input, 8 bits: opcode; 0..17 legal, 18..255 illegal.
- `req_a`, `req_b` input, 32 bits each: operands.
- `req_tag` input, 4 bits: opaque ID returned with the result.
- `rsp_valid` output, 1 bit: result register holds a result.
- `rsp_ready` input, 1 bit: consumer takes the result this cycle.
- `rsp_ql`, `rsp_qh` output, 32 bits each: low and high result words.
- `rsp_flags` output, 4 bits: captured ALU `fout`.
- `rsp_tag` output, 4 bits: tag of the request.
- `rsp_exc` output, 1 bit: illegal-opcode exception.

## Operation
- Opcode map, fixed: 0 pass (ql=a, qh=b), 1 add, 2 sub, 3 neg, 4 mul (qh:ql = 64-bit product), 5 shr, 6 shl, 7 sar, 8 sal, 9 rotr, 10 rotl, 11 not, 12 and, 13 or, 14 xor, 15 nand, 16 nor, 17 xnor. Shift amount is b[4:0]. qh=0 except for ops 0 and 4.
- A request is accepted on a rising edge where `req_valid & req_ready`. On acceptance, `req_a`, `req_b`, `req_op` and `req_tag` are latched. The ALU is driven only from these registers.
- FSM states and transitions:
  - IDLE: `req_ready` = (!`rsp_valid` | `rsp_ready`). On accept with a legal op, load the counter with `SETTLE`-1, or `MUL_SETTLE`-1 for op 4, and go to EXEC. On accept with an illegal op, go to ILL.
  - EXEC: the counter decrements each cycle. At counter==0, go to DONE.
  - DONE: if the result register is empty or being drained this cycle, capture `ql`, `qh`, `fout`, the tag, and `rsp_exc`=0; set `rsp_valid` and go to IDLE. Otherwise stay in DONE with operands held.
  - ILL: same space rule as DONE. Load `rsp_ql`=`rsp_qh`=0, `rsp_flags`=0, `rsp_exc`=1 and the tag, then go to IDLE.
- `req_ready`=0 in EXEC, DONE and ILL.
- Result register: `rsp_valid` clears on `rsp_valid & rsp_ready` unless it is reloaded on the same edge; load takes priority. Outputs stay stable while `rsp_valid & !rsp_ready`.
- Reset values: state IDLE, counter 0, all operand registers 0, `rsp_valid`=0, `rsp_ql`=`rsp_qh`=0, `rsp_flags`=0, `rsp_tag`=0, `rsp_exc`=0, `req_ready`=1 in the first cycle after reset.

## Timing
- Legal op accepted at edge T, with the response slot free: capture at edge T+S+1, where S = `SETTLE` or `MUL_SETTLE`. `rsp_valid` is high in the following cycle.
- Illegal op accepted at edge T: `rsp_valid` is high after edge T+1.
- Next acceptance is possible at the capture edge +1, or on the same cycle `rsp_ready` drains the register. Peak throughput is one op per S+2 cycles.
- Back-pressure: DONE/ILL wait indefinitely, with no loss and no duplicate results.
- `rst` asserted mid-EXEC or mid-DONE aborts the op. No response is produced for it. `rst` overrides every other input on the same edge.
- `req_*` inputs are ignored whenever `req_ready`=0.

## Structure
- Shared package `alu_pkg`: opcode constants OP_PASS..OP_XNOR (0..17), OP_LAST=17, FSM state encoding for IDLE/EXEC/DONE/ILL, and tag width 4.
- One sub-module: the existing `alu32_2x2`, instanced once, ports (ql, qh, fout, a, b, op). All sequencing lives in `alu_port`.
- Counter width 5 bits.

## Test plan
- Add: op 1, a=5, b=7, tag 3, `rsp_ready`=1 → after `SETTLE`+1 edges, ql=12, qh=0, tag 3, exc 0.
- Multiply: op 4, a=0xFFFFFFFF, b=2 → ql=0xFFFFFFFE, qh=0x00000001, response after `MUL_SETTLE`+1 edges.
- Illegal op: op 18, then op 200 → each returns exc=1, ql=qh=0 one edge after accept. The ALU result is never captured.
- Back-pressure: op 12, a=0xF0F0F0F0, b=0xFF00FF00, `rsp_ready`=0 for 40 cycles → `rsp_valid` stays high, ql stays 0xF000F000, `req_ready`=0 throughout. A second queued request (op 9, a=1, b=1) is accepted only on the drain edge and yields ql=0x80000000.
- Reset mid-op: assert `rst` 3 cycles into EXEC of op 2 → no response appears, all outputs are 0, and `req_ready`=1 in the first cycle after `rst` deasserts.
- Random: 10,000 random a, b, op 0..17 with random `rsp_ready` → every result matches the golden op model, tags come back in order, with no drops or duplicates.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, FSM encoding and widths shared by the ALU port.
package alu_pkg;
   localparam int TAG_W = 4;
   localparam int CNT_W = 5;
   localparam logic [7:0] OP_PASS = 8'd0;
   localparam logic [7:0] OP_ADD  = 8'd1;
   localparam logic [7:0] OP_SUB  = 8'd2;
   localparam logic [7:0] OP_NEG  = 8'd3;
   localparam logic [7:0] OP_MUL  = 8'd4;
   localparam logic [7:0] OP_SHR  = 8'd5;
   localparam logic [7:0] OP_SHL  = 8'd6;
   localparam logic [7:0] OP_SAR  = 8'd7;
   localparam logic [7:0] OP_SAL  = 8'd8;
   localparam logic [7:0] OP_ROTR = 8'd9;
   localparam logic [7:0] OP_ROTL = 8'd10;
   localparam logic [7:0] OP_NOT  = 8'd11;
   localparam logic [7:0] OP_AND  = 8'd12;
   localparam logic [7:0] OP_OR   = 8'd13;
   localparam logic [7:0] OP_XOR  = 8'd14;
   localparam logic [7:0] OP_NAND = 8'd15;
   localparam logic [7:0] OP_NOR  = 8'd16;
   localparam logic [7:0] OP_XNOR = 8'd17;
   localparam logic [7:0] OP_LAST = OP_XNOR;
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE, ST_ILL} state_e;
   function automatic logic op_legal(input logic [7:0] op);
      return op <= OP_LAST;
   endfunction
endpackage

// File: rtl/alu32_2x2.sv
// alu32_2x2: combinational 32-bit ALU; fout = {overflow, carry, negative, zero}.
module alu32_2x2
   import alu_pkg::*;
(
   output logic [31:0] ql,
   output logic [31:0] qh,
   output logic [3:0]  fout,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [7:0]  op
);
   logic [4:0]  sh;
   logic [5:0]  shc;
   logic [32:0] sum, dif;
   logic [63:0] prod;
   logic        c, v;
   assign sh   = b[4:0];
   assign shc  = 6'd32 - {1'b0, sh};
   assign sum  = {1'b0, a} + {1'b0, b};
   assign dif  = {1'b0, a} - {1'b0, b};
   assign prod = {32'd0, a} * {32'd0, b};
   always_comb begin
      ql = '0;
      qh = '0;
      c  = 1'b0;
      v  = 1'b0;
      case (op)
         OP_PASS: begin ql = a; qh = b; end
         OP_ADD:  begin ql = sum[31:0]; c = sum[32]; v = (a[31] == b[31]) & (sum[31] != a[31]); end
         // carry on subtract means no borrow
         OP_SUB:  begin ql = dif[31:0]; c = ~dif[32]; v = (a[31] != b[31]) & (dif[31] != a[31]); end
         OP_NEG:  begin ql = -a; v = a == 32'h8000_0000; end
         OP_MUL:  {qh, ql} = prod;
         OP_SHR:  ql = a >> sh;
         OP_SHL, OP_SAL: ql = a << sh;
         OP_SAR:  ql = 32'($signed(a) >>> sh);
         OP_ROTR: ql = (a >> sh) | (a << shc);
         OP_ROTL: ql = (a << sh) | (a >> shc);
         OP_NOT:  ql = ~a;
         OP_AND:  ql = a & b;
         OP_OR:   ql = a | b;
         OP_XOR:  ql = a ^ b;
         OP_NAND: ql = ~(a & b);
         OP_NOR:  ql = ~(a | b);
         OP_XNOR: ql = ~(a ^ b);
         default: ;
      endcase
   end
   assign fout = {v, c, ql[31], ql == '0};
endmodule

// File: rtl/alu_port.sv
// alu_port: valid/ready front-end that holds ALU operands for a settle window and registers the result.
module alu_port
   import alu_pkg::*;
#(
   parameter int SETTLE     = 8,
   parameter int MUL_SETTLE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [7:0]       req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_ql,
   output logic [31:0]      rsp_qh,
   output logic [3:0]       rsp_flags,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_exc
);
   localparam logic [CNT_W-1:0] LD     = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] LD_MUL = CNT_W'(MUL_SETTLE - 1);
   state_e             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [31:0]        a_q, b_q, alu_ql, alu_qh;
   logic [7:0]         op_q;
   logic [TAG_W-1:0]   tag_q;
   logic [3:0]         alu_f;
   logic               space, accept, cap, ill;
   alu32_2x2 u_alu (
      .ql   (alu_ql),
      .qh   (alu_qh),
      .fout (alu_f),
      .a    (a_q),
      .b    (b_q),
      .op   (op_q)
   );
   assign space     = !rsp_valid | rsp_ready;
   assign req_ready = (state == ST_IDLE) & space;
   assign accept    = req_valid & req_ready;
   assign ill       = state == ST_ILL;
   assign cap       = (state == ST_DONE | ill) & space;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_IDLE: if (accept) begin
            state_nx = op_legal(req_op) ? ST_EXEC : ST_ILL;
            cnt_nx   = !op_legal(req_op) ? cnt : req_op == OP_MUL ? LD_MUL : LD;
         end
         ST_EXEC: begin
            state_nx = cnt == '0 ? ST_DONE : ST_EXEC;
            cnt_nx   = cnt == '0 ? cnt : cnt - 1'b1;
         end
         default: state_nx = space ? ST_IDLE : state;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         tag_q     <= '0;
         rsp_valid <= 1'b0;
         rsp_ql    <= '0;
         rsp_qh    <= '0;
         rsp_flags <= '0;
         rsp_tag   <= '0;
         rsp_exc   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            a_q   <= req_a;
            b_q   <= req_b;
            op_q  <= req_op;
            tag_q <= req_tag;
         end
         // a load on the drain edge wins over the clear
         if (cap) begin
            rsp_valid <= 1'b1;
            rsp_ql    <= ill ? '0 : alu_ql;
            rsp_qh    <= ill ? '0 : alu_qh;
            rsp_flags <= ill ? '0 : alu_f;
            rsp_tag   <= tag_q;
            rsp_exc   <= ill;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end
endmodule
